alu_multicycle: RTL and testbench
=================================

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, datapath width.
REQ-002 The block SHALL have port clk_i, input, 1, single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_i, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start_i, input, 1, request to execute one operation; sampled only in IDLE.
REQ-005 The block SHALL have port ALUCtrl_i, input, 3, operation code from the ALU control decoder: 000 AND, 001 XOR, 010 SLL, 011 ADD, 100 SUB, 101 MUL, 110 ADDI, 111 SRAI.
REQ-006 The block SHALL have port data1_i, input, DATA_W, operand A (rs1).
REQ-007 The block SHALL have port data2_i, input, DATA_W, operand B (rs2 or sign-extended immediate).
REQ-008 The block SHALL have port data_o, output, DATA_W, registered result.
REQ-009 The block SHALL have port zero_o, output, 1, high when data_o == 0.
REQ-010 The block SHALL have port busy_o, output, 1, high whenever state != IDLE.
REQ-011 The block SHALL have port done_o, output, 1, one-cycle pulse marking data_o valid for the completed operation.

Function
REQ-012 FSM states: IDLE, MUL, DONE; IDLE -> DONE on start_i with non-MUL op; IDLE -> MUL on start_i with op 101; MUL -> DONE after 32nd iteration; DONE -> IDLE unconditionally.
REQ-013 Single-cycle ops: result computed from operands at the start_i edge, written to data_o on that edge; done_o high the following cycle (latency 1).
REQ-014 AND/XOR bitwise; ADD/ADDI A+B mod 2^DATA_W; SUB A-B mod 2^DATA_W; no overflow flag.
REQ-015 SLL: A << B[4:0], zero fill; SRAI: A >>> B[4:0], sign fill from A[31].
REQ-016 MUL: operands latched at start_i; radix-2 shift-add, one multiplier bit per cycle, 5-bit iteration counter 0..31; data_o = low DATA_W bits of A*B (signedness-independent).
REQ-017 MUL latency: start_i at edge N -> done_o high in cycle N+33; data_o updated on the edge entering DONE.
REQ-018 start_i while busy_o is high SHALL be ignored; operand/op changes during MUL SHALL not affect the result.
REQ-019 done_o high only in DONE, exactly one cycle per accepted start; back-to-back start accepted in IDLE the cycle after DONE.
REQ-020 data_o and zero_o SHALL hold their value between completions; zero_o derived combinationally from data_o.

Reset
REQ-021 rst_i low SHALL immediately force state IDLE, data_o = 0, counter = 0, internal accumulators = 0, busy_o = 0, done_o = 0; zero_o = 1.
REQ-022 Reset asserted mid-MUL SHALL abort the operation with no done_o pulse; first start_i after release SHALL be accepted normally.

Structure
REQ-023 Shared package alu_pkg SHALL hold the 3-bit ALUCtrl encodings, FSM state typedef, and DATA_W default, shared with the ALU control decoder.
REQ-024 The iterative multiplier SHALL be one sub-module alu_mul_iter (load, step, count, product outputs); all other ops inline.

Verification
REQ-025 Reset release, then ADD start_i with A=0x00000005, B=0xFFFFFFFD -> done_o in next cycle, data_o=0x00000002, zero_o=0.
REQ-026 SUB A=0x1234, B=0x1234 -> data_o=0, zero_o=1; SRAI A=0x80000000, B=4 -> data_o=0xF8000000; SLL A=1, B=31 -> 0x80000000.
REQ-027 MUL A=0xFFFFFFFF (-1), B=0x00000007 -> busy_o high 33 cycles, done_o at N+33, data_o=0xFFFFFFF9.
REQ-028 MUL A=3, B=5 with start_i re-pulsed and operands changed to 9/9 during MUL -> second start ignored, data_o=15, exactly one done_o.
REQ-029 rst_i low at cycle N+10 of a MUL -> busy_o=0, data_o=0, no done_o; then XOR 0xF0F0/0x0FF0 -> data_o=0xFF00 one cycle later.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings, FSM states and datapath defaults.
// Also used by the ALU control decoder.
package alu_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned OP_W       = 3;
   localparam int unsigned CNT_W      = 5;
   localparam int unsigned SHAMT_W    = 5;
   localparam int unsigned MUL_ITERS  = 32;

   typedef enum logic [OP_W-1:0] {
      OP_AND  = 3'b000,
      OP_XOR  = 3'b001,
      OP_SLL  = 3'b010,
      OP_ADD  = 3'b011,
      OP_SUB  = 3'b100,
      OP_MUL  = 3'b101,
      OP_ADDI = 3'b110,
      OP_SRAI = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } alu_state_e;

endpackage : alu_pkg

// File: rtl/alu_multicycle_if.sv
// Request/result bundle between the issuing stage (master) and the ALU (slave).
interface alu_multicycle_if
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
);
   logic              start_i;
   logic [OP_W-1:0]   ALUCtrl_i;
   logic [DATA_W-1:0] data1_i;
   logic [DATA_W-1:0] data2_i;
   logic [DATA_W-1:0] data_o;
   logic              zero_o;
   logic              busy_o;
   logic              done_o;

   modport master (
      output start_i, ALUCtrl_i, data1_i, data2_i,
      input  data_o, zero_o, busy_o, done_o
   );

   modport slave (
      input  start_i, ALUCtrl_i, data1_i, data2_i,
      output data_o, zero_o, busy_o, done_o
   );
endinterface : alu_multicycle_if

// File: rtl/alu_mul_iter.sv
// Radix-2 shift-add multiplier: one multiplier bit per step, low DATA_W bits of the product.
module alu_mul_iter
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic              step_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [CNT_W-1:0]  count_o,
   output logic [DATA_W-1:0] product_o
);

   logic [DATA_W-1:0] acc_q,    acc_d;
   logic [DATA_W-1:0] mcand_q,  mcand_d;
   logic [DATA_W-1:0] mplier_q, mplier_d;
   logic [CNT_W-1:0]  count_q,  count_d;
   logic [DATA_W-1:0] acc_step;

   // Accumulator value once the current multiplier bit has been applied.
   assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_comb begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      count_d  = count_q;
      if (load_i) begin
         acc_d    = '0;
         mcand_d  = a_i;
         mplier_d = b_i;
         count_d  = '0;
      end else if (step_i) begin
         acc_d    = acc_step;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         count_d  = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         count_q  <= '0;
      end else begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         count_q  <= count_d;
      end
   end

   assign count_o   = count_q;
   assign product_o = acc_step;

endmodule : alu_mul_iter

// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle logic/arith/shift ops inline, MUL via iterative sub-module.
module alu_multicycle
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   alu_multicycle_if.slave  bus
);

   alu_state_e        state_q, state_d;
   logic [DATA_W-1:0] data_q,  data_d;
   logic              busy_q,  busy_d;
   logic              done_q,  done_d;

   logic              mul_load_c;
   logic              mul_step_c;
   logic [CNT_W-1:0]  mul_count;
   logic [DATA_W-1:0] mul_product;
   logic [DATA_W-1:0] alu_result_c;
   logic [SHAMT_W-1:0] shamt;

   assign shamt = bus.data2_i[SHAMT_W-1:0];

   // Result of every op that completes in the start cycle.
   always_comb begin
      alu_result_c = '0;
      case (alu_op_e'(bus.ALUCtrl_i))
         OP_AND:  alu_result_c = bus.data1_i & bus.data2_i;
         OP_XOR:  alu_result_c = bus.data1_i ^ bus.data2_i;
         OP_SLL:  alu_result_c = bus.data1_i << shamt;
         OP_ADD:  alu_result_c = bus.data1_i + bus.data2_i;
         OP_SUB:  alu_result_c = bus.data1_i - bus.data2_i;
         OP_ADDI: alu_result_c = bus.data1_i + bus.data2_i;
         OP_SRAI: alu_result_c = DATA_W'($signed(bus.data1_i) >>> shamt);
         default: alu_result_c = '0;
      endcase
   end

   alu_mul_iter #(.DATA_W(DATA_W)) u_mul (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .load_i    (mul_load_c),
      .step_i    (mul_step_c),
      .a_i       (bus.data1_i),
      .b_i       (bus.data2_i),
      .count_o   (mul_count),
      .product_o (mul_product)
   );

   always_comb begin
      state_d    = state_q;
      data_d     = data_q;
      mul_load_c = 1'b0;
      mul_step_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start_i) begin
               if (alu_op_e'(bus.ALUCtrl_i) == OP_MUL) begin
                  mul_load_c = 1'b1;
                  state_d    = MUL;
               end else begin
                  data_d  = alu_result_c;
                  state_d = DONE;
               end
            end
         end
         MUL: begin
            mul_step_c = 1'b1;
            // Final step: capture the completed product on the edge entering DONE.
            if (mul_count == CNT_W'(MUL_ITERS - 1)) begin
               data_d  = mul_product;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         data_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.data_o = data_q;
   assign bus.zero_o = (data_q == '0);
   assign bus.busy_o = busy_q;
   assign bus.done_o = done_q;

endmodule : alu_multicycle

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle with a result scoreboard and latency/handshake checks.
module tb_alu_multicycle;
   import alu_pkg::*;

   localparam int unsigned W = 32;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   done_cnt;
   logic [W-1:0] exp_q[$];

   alu_multicycle_if #(.DATA_W(W)) bus ();

   alu_multicycle #(.DATA_W(W)) dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (bus.done_o === 1'b1) done_cnt++;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      logic [2*W-1:0] full;
      logic [W-1:0]   r;
      int             sh;
      sh = int'(b[4:0]);
      case (op)
         3'b000: r = a & b;
         3'b001: r = a ^ b;
         3'b010: begin
            r = a;
            for (int i = 0; i < sh; i++) r = {r[W-2:0], 1'b0};
         end
         3'b011, 3'b110: r = a + b;
         3'b100: r = a + (~b) + W'(1);
         3'b101: begin
            full = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            r    = full[W-1:0];
         end
         default: begin
            r = a;
            for (int i = 0; i < sh; i++) r = {r[W-1], r[W-1:1]};
         end
      endcase
      return r;
   endfunction

   // Drive a start pulse at a negedge; returns at the negedge of the first cycle after it.
   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit push, input logic [W-1:0] expv);
      bus.ALUCtrl_i = op;
      bus.data1_i   = a;
      bus.data2_i   = b;
      bus.start_i   = 1'b1;
      if (push) exp_q.push_back(expv);
      @(negedge clk);
      bus.start_i = 1'b0;
   endtask

   // Wait for done_o; cyc is the cycle index (1 = first cycle after the start edge) on entry.
   task automatic wait_done(input string tag, input int cyc, input int exp_lat);
      int            lat;
      int            busy_n;
      logic [W-1:0]  expv;
      lat    = cyc;
      busy_n = 0;
      while (bus.done_o !== 1'b1 && lat < 200) begin
         if (bus.busy_o === 1'b1) busy_n++;
         @(negedge clk);
         lat++;
      end
      if (bus.busy_o === 1'b1) busy_n++;
      chk({tag, "_done_seen"}, W'(bus.done_o), W'(1));
      chk({tag, "_latency"}, W'(lat), W'(exp_lat));
      chk({tag, "_busy_cycles"}, W'(busy_n), W'(exp_lat - cyc + 1));
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s_scoreboard: observed empty queue expected entry", tag);
      end else begin
         expv = exp_q.pop_front();
         chk({tag, "_data"}, bus.data_o, expv);
         chk({tag, "_zero"}, W'(bus.zero_o), W'(expv == '0));
      end
      @(negedge clk);
      chk({tag, "_done_clear"}, W'(bus.done_o), W'(0));
      chk({tag, "_idle"}, W'(bus.busy_o), W'(0));
   endtask

   initial begin
      int            dc0;
      logic [W-1:0]  ra;
      logic [W-1:0]  rb;
      logic [2:0]    rop;
      checks      = 0;
      errors      = 0;
      done_cnt    = 0;
      rst_n       = 1'b0;
      bus.start_i = 1'b0;
      bus.ALUCtrl_i = 3'b000;
      bus.data1_i = '0;
      bus.data2_i = '0;
      repeat (3) @(negedge clk);

      chk("rst_data", bus.data_o, '0);
      chk("rst_zero", W'(bus.zero_o), W'(1));
      chk("rst_busy", W'(bus.busy_o), W'(0));
      chk("rst_done", W'(bus.done_o), W'(0));
      rst_n = 1'b1;
      @(negedge clk);

      issue(OP_ADD, 32'h0000_0005, 32'hFFFF_FFFD, 1'b1, 32'h0000_0002);
      wait_done("add", 1, 1);
      issue(OP_SUB, 32'h0000_1234, 32'h0000_1234, 1'b1, 32'h0);
      wait_done("sub_zero", 1, 1);
      issue(OP_SRAI, 32'h8000_0000, 32'h0000_0004, 1'b1, 32'hF800_0000);
      wait_done("srai", 1, 1);
      issue(OP_SLL, 32'h0000_0001, 32'h0000_001F, 1'b1, 32'h8000_0000);
      wait_done("sll", 1, 1);
      issue(OP_AND, 32'hFF00_FF0F, 32'h0F0F_00FF, 1'b1, 32'h0F00_000F);
      wait_done("and", 1, 1);
      issue(OP_ADDI, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0);
      wait_done("addi_wrap", 1, 1);

      dc0 = done_cnt;
      issue(OP_MUL, 32'hFFFF_FFFF, 32'h0000_0007, 1'b1, 32'hFFFF_FFF9);
      wait_done("mul_neg", 1, 33);
      chk("mul_neg_one_done", W'(done_cnt - dc0), W'(1));

      // Second start and operand changes during MUL must be ignored.
      dc0 = done_cnt;
      issue(OP_MUL, 32'h0000_0003, 32'h0000_0005, 1'b1, 32'h0000_000F);
      repeat (5) @(negedge clk);
      bus.ALUCtrl_i = OP_ADD;
      bus.data1_i   = 32'h9;
      bus.data2_i   = 32'h9;
      bus.start_i   = 1'b1;
      @(negedge clk);
      bus.start_i   = 1'b0;
      wait_done("mul_ignore", 7, 33);
      repeat (3) @(negedge clk);
      chk("mul_ignore_one_done", W'(done_cnt - dc0), W'(1));
      chk("mul_ignore_sb_empty", W'(exp_q.size()), W'(0));

      for (int k = 0; k < 4; k++) begin
         ra  = $urandom();
         rb  = $urandom();
         rop = (k == 3) ? 3'b101 : 3'($urandom_range(0, 7));
         issue(rop, ra, rb, 1'b1, ref_alu(rop, ra, rb));
         wait_done($sformatf("rand%0d_op%0d", k, rop), 1, (rop == 3'b101) ? 33 : 1);
      end

      // Abort a MUL with reset in cycle N+10.
      issue(OP_AND, 32'h0000_00F0, 32'h0000_00FF, 1'b1, 32'h0000_00F0);
      wait_done("pre_abort", 1, 1);
      dc0 = done_cnt;
      issue(OP_MUL, 32'h0000_0006, 32'h0000_0007, 1'b0, '0);
      repeat (9) @(negedge clk);
      chk("abort_busy_before", W'(bus.busy_o), W'(1));
      rst_n = 1'b0;
      #1;
      chk("abort_busy", W'(bus.busy_o), W'(0));
      chk("abort_data", bus.data_o, '0);
      chk("abort_zero", W'(bus.zero_o), W'(1));
      chk("abort_done", W'(bus.done_o), W'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("abort_no_done", W'(done_cnt - dc0), W'(0));
      issue(OP_XOR, 32'h0000_F0F0, 32'h0000_0FF0, 1'b1, 32'h0000_FF00);
      wait_done("xor_after_rst", 1, 1);
      chk("final_sb_empty", W'(exp_q.size()), W'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_alu_multicycle
